i2c_slave_regfile: RTL and testbench

//  Open-drain I2C slave with a small byte register file, sitting downstream of i2c_master on the

---
 rtl/i2c_slave_regfile.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : Open-drain I2C target with a 2**REG_AW byte register file.
//            Oversamples scl/sda on clk_50. It never drives scl, so there is
//            no clock stretching. The first byte after the address sets the
//            register pointer. Later bytes write at the pointer, which
//            auto-increments. Reads return reg[ptr] and also auto-increment.
// Ports    : clk_50    - system clock, posedge
//            reset     - asynchronous active-high reset
//            scl       - I2C clock from master
//            sda       - I2C data, open-drain (driven 0 or z only)
//            state     - current FSM state (debug)
//            busy      - high from address match until STOP/NACK/START
//            wr_strobe - one-cycle pulse per register byte written
//            wr_addr   - register index written in the wr_strobe cycle
//            wr_data   - byte written in the wr_strobe cycle
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_AW     = 2,
  parameter logic [7:0] RESET_VAL  = 8'h00
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  output logic [3:0]        state,
  output logic              busy,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int DEPTH = 2**REG_AW;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;

  logic [2:0]        r_scl_sync;
  logic [2:0]        r_sda_sync;
  logic [3:0]        r_state;
  logic [3:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic              r_phase;    // ACK states: pulldown already started
  logic              r_ack_oe;   // pulling sda low for an ACK slot
  logic              r_tx_en;    // presenting r_shift[7] on sda
  logic              r_busy;
  logic              r_wr_strobe;
  logic [REG_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [REG_AW-1:0] r_ptr;
  logic [7:0]        r_regs [DEPTH];

  // Bits [1] are the synchronised levels and bits [2] are the previous levels.
  logic       w_scl, w_scl_d, w_sda, w_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last;
  logic [7:0] w_byte;
  logic       w_sda_low;

  assign w_scl      = r_scl_sync[1];
  assign w_scl_d    = r_scl_sync[2];
  assign w_sda      = r_sda_sync[1];
  assign w_sda_d    = r_sda_sync[2];
  assign w_scl_rise = w_scl & ~w_scl_d;
  assign w_scl_fall = ~w_scl & w_scl_d;
  // scl must be high in both samples so that a data edge near an scl edge
  // is not taken as START or STOP.
  assign w_start    = w_scl & w_scl_d & w_sda_d & ~w_sda;
  assign w_stop     = w_scl & w_scl_d & ~w_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};    // byte as of this scl_rise
  assign w_last     = (r_bitcnt == 4'd7);

  // Both pulldown sources are flops, so the async reset frees sda at once.
  assign w_sda_low  = r_ack_oe | (r_tx_en & ~r_shift[7]);
  assign sda        = w_sda_low ? 1'b0 : 1'bz;

  assign state      = r_state;
  assign busy       = r_busy;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], scl};
      r_sda_sync <= {r_sda_sync[1:0], sda};
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'd0;
      r_phase     <= 1'b0;
      r_ack_oe    <= 1'b0;
      r_tx_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_ptr       <= '0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 4'd0;
        r_phase  <= 1'b0;
        r_ack_oe <= 1'b0;
        r_tx_en  <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_phase  <= 1'b0;
        r_ack_oe <= 1'b0;
        r_tx_en  <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_bitcnt <= 4'd0;

          S_ADDR: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (w_last) begin
              r_bitcnt <= 4'd0;
              r_phase  <= 1'b0;
              if (w_byte[7:1] == SLAVE_ADDR) begin
                r_state <= S_ADDR_ACK;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end

          // The first fall starts the ACK pulldown. The second fall ends it.
          // r_shift[0] still holds the R/W bit of the address byte.
          S_ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_ack_oe <= 1'b1;
              r_phase  <= 1'b1;
            end else begin
              r_ack_oe <= 1'b0;
              r_phase  <= 1'b0;
              r_bitcnt <= 4'd0;
              if (r_shift[0]) begin
                r_state <= S_RDATA;
                r_shift <= r_regs[r_ptr];
                r_tx_en <= 1'b1;
              end else begin
                r_state <= S_REG;
              end
            end
          end

          S_REG: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (w_last) begin
              r_ptr    <= w_byte[REG_AW-1:0];
              r_state  <= S_REG_ACK;
              r_bitcnt <= 4'd0;
              r_phase  <= 1'b0;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end

          S_REG_ACK, S_WDATA_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_ack_oe <= 1'b1;
              r_phase  <= 1'b1;
            end else begin
              r_ack_oe <= 1'b0;
              r_phase  <= 1'b0;
              r_bitcnt <= 4'd0;
              r_state  <= S_WDATA;
            end
          end

          S_WDATA: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (w_last) begin
              r_regs[r_ptr] <= w_byte;
              r_wr_strobe   <= 1'b1;
              r_wr_addr     <= r_ptr;
              r_wr_data     <= w_byte;
              r_ptr         <= r_ptr + 1'b1;
              r_state       <= S_WDATA_ACK;
              r_bitcnt      <= 4'd0;
              r_phase       <= 1'b0;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end

          // Count the bits clocked out on rises and advance the shifter on
          // falls. After the eighth rise, the next fall releases sda for the
          // master's ACK.
          S_RDATA: begin
            if (w_scl_rise && r_bitcnt != 4'd8) r_bitcnt <= r_bitcnt + 4'd1;
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_tx_en  <= 1'b0;
                r_ptr    <= r_ptr + 1'b1;
                r_state  <= S_RDATA_ACK;
                r_bitcnt <= 4'd0;
                r_phase  <= 1'b0;
              end else if (r_bitcnt != 4'd0) begin
                r_shift <= {r_shift[6:0], 1'b0};
              end
            end
          end

          // After the ACK is sampled, the next byte's MSB goes out on the
          // following fall.
          S_RDATA_ACK: begin
            if (w_scl_rise && !r_phase) begin
              if (!w_sda) begin
                r_phase <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else if (w_scl_fall && r_phase) begin
              r_shift  <= r_regs[r_ptr];
              r_tx_en  <= 1'b1;
              r_phase  <= 1'b0;
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Purpose  : Bit-banged I2C master driving i2c_slave_regfile. A byte-array
//            reference model of the register file holds the expected
//            contents. Expected writes are queued and popped by a wr_strobe
//            monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

  localparam int         H        = 8;      // scl half period in clk cycles
  localparam int         AW       = 2;
  localparam int         DEPTH    = 4;
  localparam logic [3:0] ST_IDLE  = 4'd0;   // reset state encoding

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          scl    = 1'b1;
  logic          m_low  = 1'b0;
  wire           sda;
  logic [3:0]    state;
  logic          busy;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h50),
    .REG_AW     (AW),
    .RESET_VAL  (8'h00)
  ) dut (
    .clk_50    (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .state     (state),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  model [DEPTH];
  int          mptr;
  logic [9:0]  exp_wr [$];   // {addr, data}
  logic [7:0]  exp_rd [$];
  logic [7:0]  tx_q   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- bus-level master ----------------
  task automatic bus_start();
    m_low = 1'b0; cyc(H/2);
    scl   = 1'b1; cyc(H);
    m_low = 1'b1; cyc(H);
    scl   = 1'b0; cyc(H/2);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; cyc(H/2);
    scl   = 1'b1; cyc(H);
    m_low = 1'b0; cyc(H);
  endtask

  task automatic write_bit(input logic v);
    m_low = ~v; cyc(H/2);
    scl   = 1'b1; cyc(H);
    scl   = 1'b0; cyc(H/2);
  endtask

  task automatic read_bit(output logic v);
    m_low = 1'b0; cyc(H/2);
    scl   = 1'b1; cyc(H/2);
    v     = sda;  cyc(H/2);
    scl   = 1'b0; cyc(H/2);
  endtask

  task automatic send(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic recv(output logic [7:0] b, input logic nack);
    logic v;
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      read_bit(v);
      b = {b[6:0], v};
    end
    write_bit(nack);
  endtask

  // ---------------- transactions with reference model ----------------
  task automatic wr_txn(input logic [7:0] p);
    logic ack;
    bus_start();
    send(8'hA0, ack); check("wr_addr_ack", ack, 0);
    check("busy_after_match", busy, 1);
    send(p, ack);     check("wr_ptr_ack", ack, 0);
    mptr = p % DEPTH;
    foreach (tx_q[i]) begin
      exp_wr.push_back({mptr[AW-1:0], tx_q[i]});
      model[mptr] = tx_q[i];
      mptr = (mptr + 1) % DEPTH;
      send(tx_q[i], ack); check("wr_data_ack", ack, 0);
    end
    bus_stop(); cyc(4);
    check("wr_busy_after_stop", busy, 0);
    check("wr_state_after_stop", state, ST_IDLE);
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b, e;
    bus_start();
    if (set_ptr) begin
      send(8'hA0, ack); check("rd_waddr_ack", ack, 0);
      send(p, ack);     check("rd_ptr_ack", ack, 0);
      mptr = p % DEPTH;
      bus_start();
    end
    send(8'hA1, ack); check("rd_raddr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(model[mptr]);
      mptr = (mptr + 1) % DEPTH;
      recv(b, (i == n - 1));
      e = exp_rd.pop_front();
      check("rd_byte", b, e);
    end
    check("sda_released_after_nack", sda, 1);
    check("state_idle_after_nack", state, ST_IDLE);
    check("busy_low_after_nack", busy, 0);
    bus_stop(); cyc(4);
  endtask

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (!reset && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr_strobe: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        logic [9:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e[9:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ack;
    int   n;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    mptr = 0;

    cyc(3);
    check("rst_state", state, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sda", sda, 1);
    reset = 1'b0;
    cyc(H);

    // Basic write followed by a pointer-set + repeated-START read back.
    tx_q = {8'h5A, 8'hC3};
    wr_txn(8'h01);
    rd_txn(1'b1, 8'h01, 2);

    // Foreign address: no ACK anywhere, no writes.
    bus_start();
    send(8'hA2, ack); check("foreign_addr_ack", ack, 1);
    check("foreign_busy", busy, 0);
    send(8'h01, ack); check("foreign_ptr_ack", ack, 1);
    send(8'h99, ack); check("foreign_data_ack", ack, 1);
    bus_stop(); cyc(4);
    rd_txn(1'b1, 8'h00, 4);

    // Pointer wrap on writes (3 -> 0) and on reads.
    tx_q = {8'h11, 8'h22};
    wr_txn(8'h03);
    rd_txn(1'b1, 8'h03, 3);

    // The upper pointer bits are ignored.
    tx_q = {8'h7E};
    wr_txn(8'hF6);

    // A STOP after 4 data bits drops the partial byte.
    bus_start();
    send(8'hA0, ack); check("abort_addr_ack", ack, 0);
    send(8'h02, ack); check("abort_ptr_ack", ack, 0);
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    bus_stop(); cyc(4);
    check("abort_state", state, ST_IDLE);
    check("abort_busy", busy, 0);
    tx_q = {8'($urandom_range(0, 255))};
    wr_txn(8'h02);
    rd_txn(1'b1, 8'h00, 4);

    // Randomised mix of writes, pointer reads and current-address reads.
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          tx_q.delete();
          n = $urandom_range(1, 5);
          for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
          wr_txn(8'($urandom_range(0, 255)));
        end
        1: rd_txn(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 5));
        default: rd_txn(1'b0, 8'h00, $urandom_range(1, 5));
      endcase
    end

    // Reset while the slave pulls sda low for a read MSB.
    tx_q = {8'h3C, 8'hA5, 8'h5A, 8'hFF};
    wr_txn(8'h00);
    bus_start();
    send(8'hA0, ack); check("rstmid_waddr_ack", ack, 0);
    send(8'h00, ack); check("rstmid_ptr_ack", ack, 0);
    bus_start();
    send(8'hA1, ack); check("rstmid_raddr_ack", ack, 0);
    check("rstmid_slave_drives_msb", sda, 0);
    reset = 1'b1;
    #1;
    check("rstmid_sda_released", sda, 1);
    check("rstmid_state", state, ST_IDLE);
    check("rstmid_busy", busy, 0);
    cyc(2);
    scl = 1'b1; m_low = 1'b0;
    cyc(H);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    mptr = 0;
    exp_wr.delete();
    cyc(H);
    rd_txn(1'b0, 8'h00, 1);
    rd_txn(1'b1, 8'h00, 4);

    cyc(20);
    check("no_pending_writes", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
